// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI link types and constants
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    RECV,
    HOLD
  } spi_state_t;

  localparam int SPI_DATA_W  = 12;
  localparam int SPI_CLK_DIV = 11;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-stage synchroniser with rise/fall pulses
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= {STAGES{RESET_VAL}};
      prev  <= RESET_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      prev  <= chain[STAGES-1];
    end
  end

  assign q    = chain[STAGES-1];
  assign rise = chain[STAGES-1] & ~prev;
  assign fall = ~chain[STAGES-1] & prev;

endmodule

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - oversampling SPI receiver, one LSB-first word per cs-low frame
module spi_slave
  import spi_pkg::*;
#(
  parameter int DATA_W      = SPI_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs,
  input  logic              mosi,
  output logic [DATA_W-1:0] dout,
  output logic              done,
  output logic              frame_err
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int FLUSH = SYNC_STAGES + 1;
  localparam int FL_W  = $clog2(FLUSH + 1);

  logic sclk_s, sclk_rise, sclk_fall;
  logic cs_s, cs_rise, cs_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk (
    .clk(clk), .rst(rst), .d(sclk), .q(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs (
    .clk(clk), .rst(rst), .d(cs), .q(cs_s), .rise(cs_rise), .fall(cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi (
    .clk(clk), .rst(rst), .d(mosi), .q(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  // The cs chain resets high, so a cs held low through reset would fake a fall
  // while the reset values flush out; frames only start once real samples fill it.
  logic [FL_W-1:0] flush_cnt;
  logic            sync_ok;

  assign sync_ok = (flush_cnt == FL_W'(FLUSH));

  always_ff @(posedge clk) begin
    if (rst)
      flush_cnt <= '0;
    else if (!sync_ok)
      flush_cnt <= flush_cnt + 1'b1;
  end

  spi_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] shift;
  logic [DATA_W-1:0] next_word;
  logic              last_bit;

  always_comb begin
    next_word = shift;
    for (int i = 0; i < DATA_W; i++)
      if (cnt == CNT_W'(i)) next_word[i] = mosi_s;
  end

  assign last_bit = (cnt == CNT_W'(DATA_W - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      shift     <= '0;
      dout      <= '0;
      done      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      done      <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (cs_fall && sync_ok) begin
            state <= ARM;
            cnt   <= '0;
            shift <= '0;
          end
        end
        ARM: begin
          if (cs_rise)
            state <= IDLE;
          else if (sclk_rise)
            state <= RECV;
        end
        RECV: begin
          // cs_rise takes priority over a coincident sclk fall, even on the last bit
          if (cs_rise) begin
            frame_err <= 1'b1;
            state     <= IDLE;
          end else if (sclk_fall) begin
            shift <= next_word;
            cnt   <= cnt + 1'b1;
            if (last_bit) begin
              dout  <= next_word;
              done  <= 1'b1;
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (cs_rise)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - scoreboard bench for spi_slave
module tb_spi_slave;
  import spi_pkg::*;

  localparam int W    = SPI_DATA_W;
  localparam int HALF = SPI_CLK_DIV;

  logic         clk = 1'b0;
  logic         rst;
  logic         sclk;
  logic         cs;
  logic         mosi;
  logic [W-1:0] dout;
  logic         done;
  logic         frame_err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic         is_err;
    logic [W-1:0] data;
  } exp_t;

  exp_t exp_q[$];

  spi_slave #(.DATA_W(W), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi),
    .dout(dout), .done(done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    exp_t e;
    if (done && frame_err) begin
      total++;
      bad++;
      $display("FAIL both_pulses done=%b frame_err=%b required not both high", done, frame_err);
    end
    if (done) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done dout=%h required no event", dout);
      end else begin
        e = exp_q.pop_front();
        if (e.is_err !== 1'b0 || dout !== e.data) begin
          bad++;
          $display("FAIL done_word got done dout=%h required err=%b dout=%h", dout, e.is_err, e.data);
        end
      end
    end
    if (frame_err) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_frame_err dout=%h required no event", dout);
      end else begin
        e = exp_q.pop_front();
        if (e.is_err !== 1'b1 || dout !== e.data) begin
          bad++;
          $display("FAIL frame_err_event got err dout=%h required err=%b dout=%h", dout, e.is_err, e.data);
        end
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_exp(input logic is_err, input logic [W-1:0] data);
    exp_t e;
    e.is_err = is_err;
    e.data   = data;
    exp_q.push_back(e);
  endtask

  // Master-side frame: mosi changes on sclk rise. nbits may exceed W (extra random bits).
  // Aborts after nbits with cs high; if sync_abort, the final fall and cs rise coincide.
  task automatic spi_frame(input logic [W-1:0] w, input int nbits, input bit sync_abort);
    cs = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < nbits; i++) begin
      sclk = 1'b1;
      mosi = (i < W) ? w[i] : 1'($urandom_range(1));
      wait_clk(HALF);
      sclk = 1'b0;
      if (sync_abort && i == nbits - 1) cs = 1'b1;
      wait_clk(HALF);
    end
    cs = 1'b1;
    wait_clk(HALF);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) wait_clk(1);
    wait_clk(8);
  endtask

  task automatic test_reset();
    rst = 1'b1; sclk = 1'b0; cs = 1'b1; mosi = 1'b0;
    wait_clk(3);
    total++;
    if (dout !== '0 || done !== 1'b0 || frame_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs dout=%h done=%b err=%b required 000/0/0", dout, done, frame_err);
    end
    rst = 1'b0;
    wait_clk(5);
    total++;
    if (dout !== '0 || done !== 1'b0 || frame_err !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_idle dout=%h done=%b err=%b required 000/0/0", dout, done, frame_err);
    end
  endtask

  task automatic test_single();
    push_exp(1'b0, 12'hA5C);
    spi_frame(12'hA5C, W, 1'b0);
    wait_drain();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL single_drain pending=%0d required 0", exp_q.size());
    end
    total++;
    if (dout !== 12'hA5C) begin
      bad++;
      $display("FAIL single_hold dout=%h required a5c", dout);
    end
  endtask

  task automatic test_back_to_back();
    push_exp(1'b0, 12'h001);
    push_exp(1'b0, 12'hFFF);
    spi_frame(12'h001, W, 1'b0);
    wait_clk(4 * HALF - HALF);
    spi_frame(12'hFFF, W, 1'b0);
    wait_drain();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL b2b_drain pending=%0d required 0", exp_q.size());
    end
  endtask

  task automatic test_abort();
    push_exp(1'b1, 12'hFFF);
    spi_frame(12'h3C7, 5, 1'b0);
    wait_drain();
    total++;
    if (dout !== 12'hFFF) begin
      bad++;
      $display("FAIL abort_keeps_dout dout=%h required fff", dout);
    end
    push_exp(1'b0, 12'h123);
    spi_frame(12'h123, W, 1'b0);
    wait_drain();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL abort_drain pending=%0d required 0", exp_q.size());
    end
  endtask

  task automatic test_idle_sclk_and_long();
    for (int i = 0; i < 20; i++) begin
      sclk = 1'b1; mosi = 1'($urandom_range(1));
      wait_clk(HALF);
      sclk = 1'b0;
      wait_clk(HALF);
    end
    total++;
    if (exp_q.size() != 0 || dout !== 12'h123) begin
      bad++;
      $display("FAIL idle_sclk pending=%0d dout=%h required 0/123", exp_q.size(), dout);
    end
    push_exp(1'b0, 12'h5A5);
    spi_frame(12'h5A5, W + 2, 1'b0);
    wait_drain();
    total++;
    if (exp_q.size() != 0 || dout !== 12'h5A5) begin
      bad++;
      $display("FAIL long_frame pending=%0d dout=%h required 0/5a5", exp_q.size(), dout);
    end
  endtask

  task automatic test_reset_mid_frame();
    cs = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < W; i++) begin
      if (i == 6) begin
        rst = 1'b1;
        wait_clk(2);
        rst = 1'b0;
      end
      sclk = 1'b1; mosi = 1'($urandom_range(1));
      wait_clk(HALF);
      sclk = 1'b0;
      wait_clk(HALF);
    end
    cs = 1'b1;
    wait_clk(3 * HALF);
    total++;
    if (exp_q.size() != 0 || dout !== '0) begin
      bad++;
      $display("FAIL reset_mid_frame pending=%0d dout=%h required 0/000", exp_q.size(), dout);
    end
    push_exp(1'b0, 12'h777);
    spi_frame(12'h777, W, 1'b0);
    wait_drain();
    total++;
    if (exp_q.size() != 0 || dout !== 12'h777) begin
      bad++;
      $display("FAIL after_reset_frame pending=%0d dout=%h required 0/777", exp_q.size(), dout);
    end
  endtask

  task automatic test_simultaneous();
    push_exp(1'b1, 12'h777);
    spi_frame(12'h9B6, W, 1'b1);
    wait_drain();
    total++;
    if (exp_q.size() != 0 || dout !== 12'h777) begin
      bad++;
      $display("FAIL simultaneous pending=%0d dout=%h required 0/777", exp_q.size(), dout);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_abort();
    test_idle_sclk_and_long();
    test_reset_mid_frame();
    test_simultaneous();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI receiver, the far end of the team's SPI master link.
- Oversamples the incoming sclk, cs and mosi in the clk domain and deserialises one DATA_W-bit word per cs-low frame, LSB first.
- Presents the word on dout with a single-cycle done strobe.
- Sits on the peripheral side of the link; its output feeds local register/consumer logic.

Parameters:
- DATA_W, 12, bits per frame.
- SYNC_STAGES, 2, flip-flop stages on each of sclk, cs and mosi (minimum 2).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- sclk  input  1  serial clock from master; asynchronous to clk
- cs  input  1  chip select, active-low frame qualifier
- mosi  input  1  serial data; master updates it on sclk rising edge
- dout  output  DATA_W  last completed word
- done  output  1  one-clk pulse when dout updates
- frame_err  output  1  one-clk pulse when cs deasserts before DATA_W bits are received

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- Reset values: dout=0, done=0, frame_err=0, state=IDLE, bit count=0, shift register=0, synchroniser flops=sclk 0 / cs 1 / mosi 0.
- Reset mid-frame: the partial frame is discarded with no done and no frame_err. After rst releases, the next frame is only accepted after a fresh cs high-to-low transition is seen.
- Synchronisation: each input passes through SYNC_STAGES flops. Edge detect compares the last sync stage with one further registered copy:
  - sclk rise and sclk fall are one-clk pulses.
  - cs_fall and cs_rise are one-clk pulses.
- Clocking requirement: each sclk high and low phase must last at least 4 clk cycles. The system master gives 11.
- Bit sampling: mosi is sampled on synchronised sclk falling edges (mid-bit). The first sample of a frame is taken on the first falling edge that follows at least one rising edge after cs asserted.
- Bit order: the bit at count k is written to shift[k], so LSB is first. The bit counter runs 0..DATA_W-1 with no wrap.
- State machine:
  - IDLE: cs_fall -> ARM, counter cleared. All sclk activity while cs is high is ignored.
  - ARM: sclk rise -> RECV. cs_rise -> IDLE silently, since no bits were taken.
  - RECV: on sclk fall, store the bit and increment the counter.
    - When the stored bit is index DATA_W-1: dout <= assembled word, done=1 for one cycle -> HOLD.
    - cs_rise with count < DATA_W -> frame_err=1 for one cycle -> IDLE; dout is unchanged.
  - HOLD: extra sclk edges are ignored. cs_rise -> IDLE. Frames longer than DATA_W bits deliver only the first DATA_W bits.
- Simultaneous events:
  - sclk fall and cs_rise in the same clk: the bit is not sampled; cs_rise wins.
  - Last-bit fall and cs_rise in the same clk: treated as an abort, frame_err.
- Latency: done rises SYNC_STAGES+2 clk cycles after the raw sclk falling edge of the last bit, ±1 for synchroniser alignment.
- done and frame_err are never high together. dout holds its value until the next completed frame.
- Back-to-back frames: the next cs_fall is accepted on the clk after the IDLE entry.

Decomposition:
- Package spi_pkg holds:
  - the state enum (IDLE, ARM, RECV, HOLD) for spi_slave;
  - SPI_DATA_W=12, shared with the master;
  - SPI_CLK_DIV, the sclk half-period in clk cycles, for benches.
- One natural sub-module: spi_sync_edge. It is a SYNC_STAGES synchroniser with rise/fall pulse outputs, instantiated for sclk and cs; mosi uses the same synchroniser with edge outputs unused.
- Target size is roughly 150–250 lines.

Test Plan:
- Single frame, 0xA5C sent LSB first, sclk half-period 11 clk -> exactly one done pulse; dout=0xA5C; frame_err stays 0.
- Two back-to-back frames, 0x001 then 0xFFF, with cs high for 2 sclk periods between -> two done pulses; dout=0x001 then 0xFFF.
- Abort: cs rises after 5 bits of 0x3C7 -> one frame_err pulse, no done, dout keeps its prior value; a following 0x123 frame gives dout=0x123.
- sclk toggling 20 periods with cs high, then 14 sclk periods in one frame carrying 0x5A5 plus 2 extra bits -> dout=0x5A5, a single done, no error.
- rst pulsed after 6 bits, cs held low throughout -> no done and no frame_err. Then cs high, and a new 0x777 frame -> dout=0x777.
- Simultaneous events: cs_rise aligned (same synchronised clk) with the 12th sclk falling edge -> frame_err=1, done=0.
